// File: rtl/prefix_diff.sv
// rtl/prefix_diff.sv - adjacent-difference decoder kernel: a[i] = b[i] - b[i-1]
//
// Ports:
//   sys_clk, sys_rst_n         clock, asynchronous active-low reset
//   n, start                   element count and launch request (accepted in S_IDLE only)
//   busy, done, return_val     run status, one-cycle completion pulse, a[n_eff-1]
//   ld_we, ld_addr, ld_data    host write into b_mem (ignored while busy)
//   rd_addr, rd_data           host read of a_mem, registered, 1-cycle latency
//   ovf                        sticky signed-overflow flag
//
// Optional feature: define PREFIX_DIFF_OVF_EN to build the overflow detector;
// otherwise ovf is tied to 0.
module prefix_diff #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [WIDTH-1:0]  n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  return_val,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              ovf
);

  // One extra bit so n_eff and reg_i can hold DEPTH itself.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_INIT  = 5'b00010,
    S_START = 5'b00100,
    S_CALC  = 5'b01000,
    S_RET   = 5'b10000
  } state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [CNT_W-1:0]  n_eff;
  logic [CNT_W-1:0]  reg_i;
  logic [WIDTH-1:0]  reg_prev;
  logic [WIDTH-1:0]  reg_cur;
  logic [WIDTH-1:0]  reg_d;
  logic [WIDTH-1:0]  reg_ret;
  logic [ADDR_W-1:0] ret_addr;
  logic              a_we;

  logic [WIDTH-1:0]  b_mem [DEPTH];
  logic [WIDTH-1:0]  a_mem [DEPTH];

  assign ret_addr = ADDR_W'(n_eff - CNT_W'(1));
  assign a_we     = (state == S_CALC) && (cnt == 2'd2);

  // Memories are never reset; b_mem only accepts host writes while idle.
  always_ff @(posedge sys_clk) begin
    if (ld_we && !busy) b_mem[ld_addr] <= ld_data;
    if (a_we) a_mem[reg_i[ADDR_W-1:0]] <= reg_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rd_data <= '0;
    else            rd_data <= a_mem[rd_addr];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      n_eff      <= '0;
      reg_i      <= '0;
      reg_prev   <= '0;
      reg_cur    <= '0;
      reg_d      <= '0;
      reg_ret    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      return_val <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            n_eff <= (n > DEPTH_W) ? CNT_W'(DEPTH) : n[CNT_W-1:0];
            busy  <= 1'b1;
            state <= S_INIT;
          end
        end
        S_INIT: begin
          reg_i    <= '0;
          reg_prev <= '0;
          cnt      <= '0;
          state    <= S_START;
        end
        S_START: begin
          cnt   <= '0;
          state <= (reg_i >= n_eff) ? S_RET : S_CALC;
        end
        S_CALC: begin
          case (cnt)
            2'd0: begin
              reg_cur <= b_mem[reg_i[ADDR_W-1:0]];
              cnt     <= 2'd1;
            end
            2'd1: begin
              reg_d <= reg_cur - reg_prev;
              cnt   <= 2'd2;
            end
            default: begin
              // a_mem write happens in the memory block this same cycle
              reg_prev <= reg_cur;
              reg_i    <= reg_i + CNT_W'(1);
              cnt      <= '0;
              state    <= S_START;
            end
          endcase
        end
        S_RET: begin
          if (cnt == 2'd0) begin
            reg_ret <= (n_eff == '0) ? '0 : a_mem[ret_addr];
            cnt     <= 2'd1;
          end else begin
            return_val <= reg_ret;
            done       <= 1'b1;
            busy       <= 1'b0;
            cnt        <= '0;
            state      <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PREFIX_DIFF_OVF_EN
  // Signed overflow: operands differ in sign and the result's sign differs from the minuend.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf <= 1'b0;
    end else if (state == S_INIT) begin
      ovf <= 1'b0;
    end else if (a_we && (reg_cur[WIDTH-1] != reg_prev[WIDTH-1]) &&
                 (reg_d[WIDTH-1] != reg_cur[WIDTH-1])) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_prefix_diff.sv
// tb/tb_prefix_diff.sv - directed self-checking bench for prefix_diff
module tb_prefix_diff;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] n = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] return_val;
  logic        ld_we = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [7:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  prefix_diff #(.WIDTH(32), .DEPTH(256), .ADDR_W(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .n          (n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .return_val (return_val),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .ovf        (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge sys_clk);
    ld_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge sys_clk);
    rd_addr = a;
    @(posedge sys_clk);
    #1 d = rd_data;
  endtask

  // Returns the number of rising edges from the start-sampling edge until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 3000) begin
      @(posedge sys_clk);
      #1 lat++;
    end
  endtask

  task automatic launch(input logic [31:0] nn);
    @(negedge sys_clk);
    n = nn; start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input logic [31:0] nn, output int lat);
    launch(nn);
    wait_done(lat);
  endtask

  logic [31:0] d;
  int lat;

  initial begin
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_ret", return_val, 0);
    check("rst_rd", rd_data, 0);
    check("rst_ovf", {31'b0, ovf}, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // 1: basic decode
    load(0, 5); load(1, 12); load(2, 12); load(3, 20);
    run(4, lat);
    check("t1_lat", lat, 20);
    check("t1_ret", return_val, 8);
    @(posedge sys_clk); #1;
    check("t1_done_pulse", {31'b0, done}, 0);
    check("t1_busy", {31'b0, busy}, 0);
    rd(0, d); check("t1_a0", d, 5);
    rd(1, d); check("t1_a1", d, 7);
    rd(2, d); check("t1_a2", d, 0);
    rd(3, d); check("t1_a3", d, 8);

    // 2: empty run
    run(0, lat);
    check("t2_lat", lat, 4);
    check("t2_ret", return_val, 0);
    rd(0, d); check("t2_a0_kept", d, 5);

    // 3: small and wrapping differences
    load(0, 0); load(1, 1);
    run(2, lat);
    check("t3_lat", lat, 12);
    rd(0, d); check("t3_a0", d, 0);
    rd(1, d); check("t3_a1", d, 1);
    load(0, 1); load(1, 0);
    run(2, lat);
    rd(1, d); check("t3_a1_wrap", d, 32'hFFFF_FFFF);
    check("t3_ret_wrap", return_val, 32'hFFFF_FFFF);

    // 4: start and ld_we during a run are ignored
    load(0, 5); load(1, 12); load(2, 12); load(3, 20);
    done_cnt = 0;
    launch(4);
    repeat (5) @(posedge sys_clk);
    #1 start = 1'b1; ld_we = 1'b1; ld_addr = 8'd3; ld_data = 32'd99;
    @(posedge sys_clk);
    #1 start = 1'b0; ld_we = 1'b0;
    wait_done(lat);
    check("t4_done_seen", {31'b0, done}, 1);
    check("t4_ret", return_val, 8);
    repeat (30) @(posedge sys_clk);
    #1;
    check("t4_done_count", done_cnt, 1);
    check("t4_idle", {31'b0, busy}, 0);
    run(4, lat);
    check("t4_b_unchanged", return_val, 8);

    // 5: reset mid-S_CALC
    launch(4);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    check("t5_busy", {31'b0, busy}, 0);
    check("t5_ret", return_val, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run(4, lat);
    check("t5_lat", lat, 20);
    check("t5_ret_after", return_val, 8);

    // clamp: n > DEPTH behaves as n = 256
    load(254, 10); load(255, 3);
    run(300, lat);
    check("clamp_lat", lat, 1028);
    check("clamp_ret", return_val, 32'hFFFF_FFF9);

    // 6: overflow flag
    load(0, 32'h8000_0000); load(1, 32'h7FFF_FFFF);
    run(2, lat);
    check("t6_ret_a", return_val, 32'hFFFF_FFFF);
`ifdef PREFIX_DIFF_OVF_EN
    check("t6_ovf_a", {31'b0, ovf}, 1);
`else
    check("t6_ovf_a", {31'b0, ovf}, 0);
`endif
    load(0, 32'h7FFF_FFFF); load(1, 32'h8000_0000);
    run(2, lat);
    check("t6_ret_b", return_val, 1);
`ifdef PREFIX_DIFF_OVF_EN
    check("t6_ovf_b", {31'b0, ovf}, 1);
`else
    check("t6_ovf_b", {31'b0, ovf}, 0);
`endif
    load(0, 1); load(1, 3);
    run(2, lat);
    check("t6_ret_c", return_val, 2);
    check("t6_ovf_cleared", {31'b0, ovf}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
